// File: rtl/stream_stall_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_stall_fifo_pkg
// Description : Shared stream word definitions for the preprocessing stage and
//               the elastic output buffer, plus the upstream-stall threshold
//               helper used by the buffer control logic.
// Contents    : STREAM_WIDTH - stream word width in bits
//               word_t       - one stream word
//               stall_threshold() - occupancy at which upstream stall asserts
// Revision    : 1.0 - initial release
// ============================================================================
package stream_stall_fifo_pkg;

    localparam int STREAM_WIDTH = 32;

    typedef logic [STREAM_WIDTH-1:0] word_t;

    // Occupancy (after the current edge) at which the producer is told to stop.
    // The extra entry on top of SLACK covers the cycle between the producer
    // seeing the stall and its last in-flight word landing.
    function automatic int unsigned stall_threshold(input int unsigned depth,
                                                    input int unsigned slack);
        return depth - slack - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_stall_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_stall_fifo_if
// Description : Valid/stall word stream. The sender drives data and valid;
//               the receiver drives stall back. A word transfers on every
//               cycle valid is 1 -- there is no ready/ack handshake.
// Signals     : data  [WIDTH] - stream word
//               valid [1]     - data is a word this cycle
//               stall [1]     - receiver back-pressure
// Modports    : master - sender side   (drives data/valid, sees stall)
//               slave  - receiver side (sees data/valid, drives stall)
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_stall_fifo_if
    import stream_stall_fifo_pkg::*;
#(
    parameter int WIDTH = STREAM_WIDTH
);

    logic [WIDTH-1:0] data;
    logic             valid;
    logic             stall;

    modport master (
        output data,
        output valid,
        input  stall
    );

    modport slave (
        input  data,
        input  valid,
        output stall
    );

endinterface
`default_nettype wire

// File: rtl/stream_stall_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : stream_stall_fifo_mem
// Description : DEPTH x WIDTH register-array storage for the stream FIFO.
//               One synchronous write port, one combinational read port.
//               No reset: validity of entries is tracked by the controller.
// Ports       : clock   in  1             rising-edge clock
//               wr_en   in  1             write wr_data at wr_addr this edge
//               wr_addr in  log2(DEPTH)   write address
//               wr_data in  WIDTH         write data
//               rd_addr in  log2(DEPTH)   read address
//               rd_data out WIDTH         word stored at rd_addr (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module stream_stall_fifo_mem
    import stream_stall_fifo_pkg::*;
#(
    parameter int WIDTH = STREAM_WIDTH,
    parameter int DEPTH = 16
) (
    input  wire logic                     clock,
    input  wire logic                     wr_en,
    input  wire logic [$clog2(DEPTH)-1:0] wr_addr,
    input  wire logic [WIDTH-1:0]         wr_data,
    input  wire logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic      [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/stream_stall_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stream_stall_fifo
// Description : Elastic output buffer between the image-preprocessing stage
//               and the host-facing consumer. Absorbs a valid/stall word
//               stream, re-presents it from a registered output stage, turns
//               consumer back-pressure into a registered early-warning
//               upstream stall, and reports occupancy plus a sticky overflow.
// Parameters  : WIDTH - word width
//               DEPTH - FIFO entries, power of two and >= 4
//               SLACK - words the producer may still send after it sees
//                       upstream stall; must satisfy SLACK <= DEPTH-2
// Ports       : clock    in   1              rising-edge clock
//               reset    in   1              synchronous, active-low
//               in_if    slave               producer stream (stall = upstream stall)
//               out_if   master              consumer stream (stall = downstream stall)
//               count    out  log2(DEPTH)+1  buffered words, output register excluded
//               overflow out  1              sticky: a word arrived while full
// Revision    : 1.0 - initial release
// ============================================================================
module stream_stall_fifo
    import stream_stall_fifo_pkg::*;
#(
    parameter int WIDTH = STREAM_WIDTH,
    parameter int DEPTH = 16,
    parameter int SLACK = 2
) (
    input  wire logic                   clock,
    input  wire logic                   reset,
    stream_stall_fifo_if.slave          in_if,
    stream_stall_fifo_if.master         out_if,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_stall_at = c_cnt_w'(stall_threshold(DEPTH, SLACK));
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_valid;
    logic               r_upstream_stall;
    logic               r_overflow;

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   w_head;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [c_cnt_w-1:0] w_count_next;

    always_comb begin
        // The consumer's stall is looked at only at the edge, so a stall
        // raised in cycle t still lets the word popped at edge t-1 show.
        w_pop  = !out_if.stall && (r_count != '0);

        // A full FIFO still takes a word when a pop frees an entry at the
        // same edge. At count==0 the pushed word is only written: the read
        // port shows the old head slot, so it is popped one edge later.
        w_push = in_if.valid && ((r_count != c_full) || w_pop);
        w_drop = in_if.valid && !w_push;

        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_cnt_one;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_cnt_one;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    stream_stall_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr),
        .wr_data (in_if.data),
        .rd_addr (r_rd_ptr),
        .rd_data (w_head)
    );

    // ------------------------------------------------------------------
    // Pointers, occupancy, output stage and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rd_ptr         <= '0;
            r_wr_ptr         <= '0;
            r_count          <= '0;
            r_out_data       <= '0;
            r_out_valid      <= 1'b0;
            r_overflow       <= 1'b0;
            // Hold the producer off while in reset; released on the first
            // edge after reset goes high.
            r_upstream_stall <= 1'b1;
        end else begin
            if (w_pop) begin
                r_out_data  <= w_head;
                r_out_valid <= 1'b1;
                r_rd_ptr    <= r_rd_ptr + c_ptr_one;
            end else begin
                r_out_valid <= 1'b0;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            r_count <= w_count_next;

            // Decided on post-edge occupancy so the warning is already
            // registered while the SLACK in-flight words are still arriving.
            r_upstream_stall <= (w_count_next >= c_stall_at);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_if.stall  = r_upstream_stall;
    assign out_if.data  = r_out_data;
    assign out_if.valid = r_out_valid;
    assign count        = r_count;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_stream_stall_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_stall_fifo
// Description : Self-checking bench for stream_stall_fifo. A cycle table
//               covers reset and the basic pass-through; hand sequences cover
//               full/overflow/reset corners; a queue-based reference model
//               checks a well-behaved producer phase and a random phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_stall_fifo;
    import stream_stall_fifo_pkg::*;

    localparam int WIDTH = STREAM_WIDTH;
    localparam int DEPTH = 16;
    localparam int SLACK = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int THR   = DEPTH - SLACK - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    stream_stall_fifo_if #(.WIDTH(WIDTH)) in_if ();
    stream_stall_fifo_if #(.WIDTH(WIDTH)) out_if ();
    logic [CW-1:0] count;
    logic          overflow;

    stream_stall_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .SLACK (SLACK)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_if    (in_if.slave),
        .out_if   (out_if.master),
        .count    (count),
        .overflow (overflow)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: the buffer is a queue of at most DEPTH words.
    word_t mq[$];
    bit    m_ov;
    word_t m_od;
    bit    m_ovf;
    bit    m_us;

    word_t got[$];
    word_t sent[$];

    function automatic void model_edge(input bit rst_n, input bit iv,
                                       input word_t id, input bit ds);
        if (!rst_n) begin
            mq.delete();
            m_ov  = 1'b0;
            m_od  = '0;
            m_ovf = 1'b0;
            m_us  = 1'b1;
            return;
        end
        if (!ds && mq.size() > 0) begin
            m_od = mq.pop_front();
            m_ov = 1'b1;
        end else begin
            m_ov = 1'b0;
        end
        if (iv) begin
            if (mq.size() < DEPTH) mq.push_back(id);
            else                   m_ovf = 1'b1;
        end
        m_us = (mq.size() >= THR);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, sample #1 later.
    task automatic step(input bit rst_n, input bit iv, input word_t id,
                        input bit ds, input bit cmp);
        reset        = rst_n;
        in_if.valid  = iv;
        in_if.data   = id;
        out_if.stall = ds;
        @(posedge clock);
        model_edge(rst_n, iv, id, ds);
        #1;
        if (cmp) begin
            chk("out_valid",      32'(out_if.valid), 32'(m_ov));
            chk("out_data",       out_if.data,       m_od);
            chk("count",          32'(count),        32'(mq.size()));
            chk("upstream_stall", 32'(in_if.stall),  32'(m_us));
            chk("overflow",       32'(overflow),     32'(m_ovf));
        end
        if (out_if.valid) got.push_back(out_if.data);
    endtask

    typedef struct {
        bit    rst_n;
        bit    iv;
        word_t id;
        bit    ds;
        bit    e_ov;
        word_t e_od;
        int    e_cnt;
        bit    e_us;
        bit    e_ovf;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int    sc;
        int    peak;
        int    cnt_at_stall;
        bit    iv;
        bit    ds;
        word_t d;

        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.stall = 1'b0;

        // ---------------- reset + back-to-back pass-through ----------------
        //            rst  iv  data        ds   ov  od       cnt us  ovf
        tbl[0]  = '{1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b0, 32'h0, 0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b0, 32'h0, 0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b0, 32'h0, 0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 32'h1,    1'b0, 1'b0, 32'h0, 1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 32'h2,    1'b0, 1'b1, 32'h1, 1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 32'h3,    1'b0, 1'b1, 32'h2, 1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 32'h4,    1'b0, 1'b1, 32'h3, 1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 32'h5,    1'b0, 1'b1, 32'h4, 1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 32'h5, 0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 32'h5, 0, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst_n, tbl[i].iv, tbl[i].id, tbl[i].ds, 1'b0);
            chk($sformatf("tbl%0d.out_valid", i), 32'(out_if.valid), 32'(tbl[i].e_ov));
            chk($sformatf("tbl%0d.out_data", i),  out_if.data,       tbl[i].e_od);
            chk($sformatf("tbl%0d.count", i),     32'(count),        32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d.ustall", i),    32'(in_if.stall),  32'(tbl[i].e_us));
            chk($sformatf("tbl%0d.overflow", i),  32'(overflow),     32'(tbl[i].e_ovf));
        end

        // ---------------- full FIFO, push + pop at the same edge ----------------
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, word_t'(32'h200 + i), 1'b1, 1'b1);
        chk("full.count", 32'(count), 32'd16);
        chk("full.ustall", 32'(in_if.stall), 32'd1);
        got.delete();
        step(1'b1, 1'b1, 32'h210, 1'b0, 1'b0);
        chk("fullpp.count", 32'(count), 32'd16);
        chk("fullpp.overflow", 32'(overflow), 32'd0);
        chk("fullpp.out_valid", 32'(out_if.valid), 32'd1);
        chk("fullpp.out_data", out_if.data, 32'h200);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("fullpp.n_out", 32'(got.size()), 32'd17);
        for (int i = 0; i < got.size() && i < 17; i++)
            chk($sformatf("fullpp.word%0d", i), got[i], 32'h200 + i);

        // ---------------- producer ignores stall: overflow ----------------
        for (int i = 0; i < 18; i++) step(1'b1, 1'b1, word_t'(32'h100 + i), 1'b1, 1'b1);
        chk("ovf.count", 32'(count), 32'd16);
        chk("ovf.flag", 32'(overflow), 32'd1);
        got.delete();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("ovf.n_out", 32'(got.size()), 32'd16);
        for (int i = 0; i < got.size() && i < 16; i++)
            chk($sformatf("ovf.word%0d", i), got[i], 32'h100 + i);
        chk("ovf.sticky", 32'(overflow), 32'd1);

        // ---------------- reset with words buffered ----------------
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, word_t'(32'h400 + i), 1'b1, 1'b1);
        chk("rst8.count_before", 32'(count), 32'd8);
        step(1'b0, 1'b1, 32'h4FF, 1'b0, 1'b0);
        chk("rst8.count", 32'(count), 32'd0);
        chk("rst8.out_valid", 32'(out_if.valid), 32'd0);
        chk("rst8.overflow", 32'(overflow), 32'd0);
        chk("rst8.ustall", 32'(in_if.stall), 32'd1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        got.delete();
        step(1'b1, 1'b1, 32'hABCD, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("rst8.n_out", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("rst8.first_word", got[0], 32'hABCD);

        // ---------------- well-behaved producer against a 30-cycle stall ----------------
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        got.delete();
        sent.delete();
        sc = 0;
        peak = 0;
        cnt_at_stall = -1;
        for (int k = 0; k < 70; k++) begin
            if (in_if.stall) sc++; else sc = 0;
            iv = (sc <= SLACK);
            ds = (k < 30);
            d  = word_t'(32'h300 + k);
            if (iv && k < 30) sent.push_back(d);
            step(1'b1, iv && (k < 30), d, ds, 1'b1);
            if (int'(count) > peak) peak = int'(count);
            if (in_if.stall && cnt_at_stall < 0) cnt_at_stall = int'(count);
        end
        chk("slack.stall_at", 32'(cnt_at_stall), 32'(THR));
        chk("slack.peak_le_depth", 32'(peak <= DEPTH), 32'd1);
        chk("slack.overflow", 32'(overflow), 32'd0);
        chk("slack.n_out", 32'(got.size()), 32'(sent.size()));
        for (int i = 0; i < got.size() && i < sent.size(); i++)
            chk($sformatf("slack.word%0d", i), got[i], sent[i]);

        // ---------------- random traffic against the model ----------------
        sc = 0;
        for (int k = 0; k < 1500; k++) begin
            if (in_if.stall) sc++; else sc = 0;
            iv = (sc <= SLACK) && ($urandom_range(99) < 75);
            ds = ($urandom_range(99) < ((k / 250) % 2 == 0 ? 20 : 60));
            step(1'b1, iv, word_t'($urandom), ds, 1'b1);
        end
        for (int k = 0; k < 40; k++) step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("rand.drained", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
